// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer
//   Reads a run of consecutive words out of a simple-dual BRAM read port and
//   presents them as an AXI-Stream style beat sequence. Word index wraps
//   modulo WL. Output is buffered by a 2-entry FIFO so backpressure never
//   loses data, and one beat per cycle is sustained with m_tready held high.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; base_idx/len sampled with start
//   RUN   | issuing reads (at most one per cycle) while FIFO has room
//   DRAIN | all reads issued; emptying FIFO until the tlast handshake
//   FIN   | one-cycle done pulse, then back to IDLE
//
// Ports
//   CLK, RSTN          clock, asynchronous active-low reset
//   start, base_idx,   job request with first word index and word count
//   len                (len = 0 completes with no beats)
//   abort              synchronous cancel of a job in RUN/DRAIN
//   busy, done         status; done pulses for exactly the FIN cycle
//   bram_EN/WE/A/Do    BRAM read port (byte address, 1-cycle read latency)
//   m_tdata/tvalid/    stream output
//   tready/tlast
module bram_rd_streamer #(
   parameter int DW = 128,
   parameter int WL = 512
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          start,
   input  logic [8:0]    base_idx,
   input  logic [9:0]    len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          bram_EN,
   output logic [3:0]    bram_WE,
   output logic [12:0]   bram_A,
   input  logic [DW-1:0] bram_Do,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic          m_tlast
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t          state, state_nxt;
   logic [8:0]      rd_idx;
   logic [9:0]      rd_left;
   logic [9:0]      beat_left;
   logic            rd_pend;
   logic [DW-1:0]   fifo_mem [2];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      fifo_cnt;

   logic            accept, abort_job, pop, issue, last_beat;
   logic [8:0]      rd_idx_nxt;

   assign accept    = (state == IDLE) && start;
   assign abort_job = abort && ((state == RUN) || (state == DRAIN));
   assign pop       = m_tvalid && m_tready && !abort_job;
   assign last_beat = (beat_left == 10'd1);

   // Room check counts the FIFO, the read whose data is on bram_Do now, and
   // credits a beat leaving this cycle; never more than 2 words outstanding.
   assign issue = (state == RUN) && (rd_left != 10'd0) && !abort_job &&
                  (({1'b0, fifo_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

   assign rd_idx_nxt = (rd_idx == 9'(WL - 1)) ? 9'd0 : rd_idx + 9'd1;

   assign busy     = (state != IDLE);
   assign done     = (state == FIN);
   assign bram_EN  = (state == RUN) || (state == DRAIN);
   assign bram_WE  = 4'b0000;
   assign bram_A   = {2'b00, rd_idx, 2'b00};
   assign m_tvalid = (fifo_cnt != 2'd0);
   assign m_tdata  = fifo_mem[rd_ptr];
   assign m_tlast  = m_tvalid && last_beat;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = (len == 10'd0) ? FIN : RUN;
         end
         RUN: begin
            if (abort_job)                           state_nxt = IDLE;
            else if (issue && (rd_left == 10'd1))    state_nxt = DRAIN;
         end
         DRAIN: begin
            if (abort_job)                           state_nxt = IDLE;
            else if (pop && last_beat)               state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state     <= IDLE;
         rd_idx    <= '0;
         rd_left   <= '0;
         beat_left <= '0;
         rd_pend   <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= '0;
         for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      end else begin
         state <= state_nxt;

         if (accept) begin
            rd_idx    <= base_idx;
            rd_left   <= len;
            beat_left <= len;
         end else begin
            if (issue) begin
               rd_idx  <= rd_idx_nxt;
               rd_left <= rd_left - 10'd1;
            end
            if (pop) beat_left <= beat_left - 10'd1;
         end

         if (abort_job) begin
            rd_pend  <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
         end else begin
            rd_pend <= issue;
            if (rd_pend) begin
               fifo_mem[wr_ptr] <= bram_Do;
               wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_bram_rd_streamer.sv
module tb_bram_rd_streamer;
   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          start = 1'b0;
   logic [8:0]    base_idx = '0;
   logic [9:0]    len = '0;
   logic          abort = 1'b0;
   logic          busy, done, bram_EN, m_tvalid, m_tlast;
   logic          m_tready = 1'b0;
   logic [3:0]    bram_WE;
   logic [12:0]   bram_A;
   logic [DW-1:0] bram_Do, m_tdata;

   bram_rd_streamer #(.DW(DW), .WL(512)) dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .base_idx(base_idx), .len(len),
      .abort(abort), .busy(busy), .done(done), .bram_EN(bram_EN),
      .bram_WE(bram_WE), .bram_A(bram_A), .bram_Do(bram_Do),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] ram [512];
   initial for (int i = 0; i < 512; i++) ram[i] = DW'(i);
   always @(posedge CLK) if (bram_EN) bram_Do <= ram[bram_A[10:2]];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: 0 idle, 1 job active (beats outstanding), 2 done cycle
   int            mst = 0;
   int            m_base, m_len, m_beat, m_cyc;
   bit            m_allready;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data;
   int            got[$];
   int            a_seen[$];
   int            done_cyc = -1;
   int            last_cnt = 0;
   int            tlast_idx = -1;
   int            valid_cnt = 0;

   // Inputs are set before calling; outputs sampled 2 time units after the edge.
   task automatic cycle();
      bit hs;
      int n;
      #1;
      chk("bram_we", DW'(bram_WE), DW'(0));
      if (done) done_cyc = m_cyc;
      case (mst)
         0: begin
            chk("idle_busy",  DW'(busy),     DW'(0));
            chk("idle_done",  DW'(done),     DW'(0));
            chk("idle_en",    DW'(bram_EN),  DW'(0));
            chk("idle_valid", DW'(m_tvalid), DW'(0));
            chk("idle_tlast", DW'(m_tlast),  DW'(0));
         end
         2: begin
            chk("fin_busy",  DW'(busy),     DW'(1));
            chk("fin_done",  DW'(done),     DW'(1));
            chk("fin_en",    DW'(bram_EN),  DW'(0));
            chk("fin_valid", DW'(m_tvalid), DW'(0));
         end
         default: begin
            chk("run_busy", DW'(busy),    DW'(1));
            chk("run_done", DW'(done),    DW'(0));
            chk("run_en",   DW'(bram_EN), DW'(1));
            if (m_allready) chk("valid_timing", DW'(m_tvalid), DW'(m_cyc >= 2));
            if (m_allready && m_cyc < m_len)
               chk("addr_seq", DW'(bram_A), DW'(((m_base + m_cyc) % 512) * 4));
            if (m_tvalid) begin
               chk("tdata", m_tdata, DW'((m_base + m_beat) % 512));
               chk("tlast", DW'(m_tlast), DW'(m_beat == m_len - 1));
            end
            if (prev_stall) begin
               chk("stall_valid", DW'(m_tvalid), DW'(1));
               chk("stall_data",  m_tdata, prev_data);
            end
            n = (int'(bram_A[10:2]) - m_base + 512) % 512;
            chk("outstanding", DW'((n - m_beat) <= 2), DW'(1));
         end
      endcase
      hs = m_tvalid && m_tready && !abort;
      if (m_tvalid && mst != 0) valid_cnt++;
      if (mst == 1 && m_cyc < 4) a_seen.push_back(int'(bram_A));
      if (mst == 1 && hs) begin
         if (m_tlast) begin
            last_cnt++;
            tlast_idx = got.size();
         end
         got.push_back(int'(m_tdata[31:0]));
      end
      prev_stall = (mst == 1) && m_tvalid && !m_tready && !abort;
      prev_data  = m_tdata;
      case (mst)
         0: if (start) begin
            m_base = int'(base_idx); m_len = int'(len);
            m_beat = 0; m_cyc = 0; m_allready = 1;
            got.delete(); a_seen.delete();
            done_cyc = -1; last_cnt = 0; tlast_idx = -1; valid_cnt = 0;
            mst = (len == 10'd0) ? 2 : 1;
         end
         1: begin
            if (abort) begin
               mst = 0;
               prev_stall = 0;
            end else begin
               if (!m_tready) m_allready = 0;
               if (hs) begin
                  m_beat++;
                  if (m_beat == m_len) mst = 2;
               end
               m_cyc++;
            end
         end
         default: mst = 0;
      endcase
      @(posedge CLK);
      #1;
   endtask

   // mode 0: m_tready=1 throughout; mode 1: 1,0,0,1 repeating
   task automatic run_job(input int b, input int l, input int mode, input int abort_after);
      int k;
      k = 0;
      base_idx = 9'(b);
      len      = 10'(l);
      start    = 1'b1;
      m_tready = 1'b1;
      cycle();
      start = 1'b0;
      k++;
      for (int c = 0; c < 4 * l + 40 && mst != 0; c++) begin
         m_tready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         abort    = (abort_after >= 0) && (mst == 1) && (m_beat == abort_after);
         cycle();
         k++;
      end
      abort    = 1'b0;
      m_tready = 1'b0;
      chk("job_ended", DW'(mst == 0), DW'(1));
   endtask

   initial begin
      RSTN = 1'b0;
      #2;
      chk("rst_busy",  DW'(busy),     DW'(0));
      chk("rst_done",  DW'(done),     DW'(0));
      chk("rst_en",    DW'(bram_EN),  DW'(0));
      chk("rst_addr",  DW'(bram_A),   DW'(0));
      chk("rst_valid", DW'(m_tvalid), DW'(0));
      chk("rst_tlast", DW'(m_tlast),  DW'(0));
      chk("rst_tdata", m_tdata,       DW'(0));
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;

      // Basic job
      run_job(5, 4, 0, -1);
      chk("basic_cnt",   DW'(got.size()), DW'(4));
      chk("basic_b0",    DW'(got[0]),     DW'(5));
      chk("basic_b3",    DW'(got[3]),     DW'(8));
      chk("basic_tlast", DW'(tlast_idx),  DW'(3));
      chk("basic_done",  DW'(done_cyc),   DW'(6));

      // Wrap-around
      run_job(510, 4, 0, -1);
      chk("wrap_a0", DW'(a_seen[0]), DW'(13'h7F8));
      chk("wrap_a1", DW'(a_seen[1]), DW'(13'h7FC));
      chk("wrap_a2", DW'(a_seen[2]), DW'(13'h000));
      chk("wrap_a3", DW'(a_seen[3]), DW'(13'h004));
      chk("wrap_b2", DW'(got[2]),    DW'(0));
      chk("wrap_b3", DW'(got[3]),    DW'(1));

      // Backpressure
      run_job(20, 8, 1, -1);
      chk("bp_cnt",   DW'(got.size()),    DW'(8));
      chk("bp_b7",    DW'(got[7]),        DW'(27));
      chk("bp_last",  DW'(last_cnt),      DW'(1));
      chk("bp_done",  DW'(done_cyc >= 0), DW'(1));

      // Zero length
      run_job(33, 0, 0, -1);
      chk("zero_done",  DW'(done_cyc),   DW'(0));
      chk("zero_beats", DW'(got.size()), DW'(0));
      chk("zero_valid", DW'(valid_cnt),  DW'(0));

      // Full depth
      run_job(300, 512, 0, -1);
      chk("full_cnt",   DW'(got.size()), DW'(512));
      chk("full_tlast", DW'(tlast_idx),  DW'(511));
      chk("full_lastn", DW'(last_cnt),   DW'(1));
      chk("full_b511",  DW'(got[511]),   DW'(299));

      // Abort after 3 beats, then a short job
      run_job(40, 10, 0, 3);
      chk("abort_cnt",  DW'(got.size()), DW'(3));
      chk("abort_done", DW'(done_cyc),   DW'(-1));
      cycle();
      cycle();
      run_job(60, 2, 0, -1);
      chk("post_abort_b0",   DW'(got[0]),   DW'(60));
      chk("post_abort_b1",   DW'(got[1]),   DW'(61));
      chk("post_abort_done", DW'(done_cyc), DW'(4));

      // Reset while in DRAIN with the sink stalled
      base_idx = 9'd100;
      len      = 10'd2;
      start    = 1'b1;
      m_tready = 1'b0;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      chk("pre_rst_valid", DW'(m_tvalid), DW'(1));
      RSTN = 1'b0;
      #1;
      chk("mid_rst_busy",  DW'(busy),     DW'(0));
      chk("mid_rst_done",  DW'(done),     DW'(0));
      chk("mid_rst_en",    DW'(bram_EN),  DW'(0));
      chk("mid_rst_addr",  DW'(bram_A),   DW'(0));
      chk("mid_rst_valid", DW'(m_tvalid), DW'(0));
      chk("mid_rst_tlast", DW'(m_tlast),  DW'(0));
      chk("mid_rst_tdata", m_tdata,       DW'(0));
      mst = 0;
      prev_stall = 0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      run_job(7, 3, 0, -1);
      chk("post_rst_b0",   DW'(got[0]),     DW'(7));
      chk("post_rst_cnt",  DW'(got.size()), DW'(3));
      chk("post_rst_done", DW'(done_cyc),   DW'(5));
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
